// File: rtl/iir_resp_capture_pkg.sv
// ----------------------------------------------------------------------------
// iir_pkg
// Shared declarations for the IIR frequency-response capture block:
//   - state_t   : capture FSM encoding (3 bits)
//   - CONFIG_SIZE_DEF / DATA_BITS_DEF : default widths
//   - sample_t  : packed {mag, phase} buffer word at the default width
// ----------------------------------------------------------------------------
package iir_pkg;

    localparam int CONFIG_SIZE_DEF = 16;
    localparam int DATA_BITS_DEF   = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQUEST = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    typedef struct packed {
        logic [DATA_BITS_DEF-1:0] mag;
        logic [DATA_BITS_DEF-1:0] phase;
    } sample_t;

endpackage

// File: rtl/iir_resp_capture_if.sv
// ----------------------------------------------------------------------------
// iir_resp_capture_if
// Bundles the evaluator stream and the downstream read port.
//   Evaluator stream : eval_iir_freq_resp (request), tf_val_magnitude,
//                      tf_val_phase, tf_val_valid, freq_eval_done
//   Read port        : rd_en, rd_addr -> rd_magnitude, rd_phase, rd_valid
// Modports:
//   slave  - the capture block (consumes samples, serves reads)
//   master - the environment (evaluator + deconvolution datapath)
// ----------------------------------------------------------------------------
interface iir_resp_capture_if
    import iir_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int ADDR_BITS = 10
);
    logic                 eval_iir_freq_resp;
    logic [DATA_BITS-1:0] tf_val_magnitude;
    logic [DATA_BITS-1:0] tf_val_phase;
    logic                 tf_val_valid;
    logic                 freq_eval_done;

    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [DATA_BITS-1:0] rd_magnitude;
    logic [DATA_BITS-1:0] rd_phase;
    logic                 rd_valid;

    modport slave (
        output eval_iir_freq_resp,
        input  tf_val_magnitude,
        input  tf_val_phase,
        input  tf_val_valid,
        input  freq_eval_done,
        input  rd_en,
        input  rd_addr,
        output rd_magnitude,
        output rd_phase,
        output rd_valid
    );

    modport master (
        input  eval_iir_freq_resp,
        output tf_val_magnitude,
        output tf_val_phase,
        output tf_val_valid,
        output freq_eval_done,
        output rd_en,
        output rd_addr,
        input  rd_magnitude,
        input  rd_phase,
        input  rd_valid
    );

endinterface

// File: rtl/iir_resp_capture_mem.sv
// ----------------------------------------------------------------------------
// resp_buffer_mem
// Single-port DEPTH x WIDTH storage with a registered (1-cycle) read.
// Kept as a plain array so it can be replaced by an SRAM macro; contents and
// read register are deliberately not reset.
// Ports:
//   clk   - clock
//   we    - write enable (writes wdata to addr)
//   re    - read enable (rdata <= mem[addr] on the next edge)
//   addr  - shared read/write address
//   wdata - write data
//   rdata - registered read data, held while re is low
// ----------------------------------------------------------------------------
module resp_buffer_mem #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = 10,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/iir_resp_capture.sv
// ----------------------------------------------------------------------------
// iir_resp_capture
// Requests an IIR frequency-response sweep from the evaluator, captures one
// {magnitude, phase} sample per tf_val_valid beat into an NFFT-deep buffer,
// and once a complete vector is held serves 1-cycle random-access reads.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   config_nfft   - bin count, latched on an accepted start
//   start         - single-cycle capture request
//   busy          - accepted start until DONE/ERROR
//   capture_done  - buffer holds a complete vector
//   error         - sticky fault, cleared by the next accepted start
//   bus (slave)   - evaluator stream and read port (see iir_resp_capture_if)
//
// Optional feature: define IIR_RESP_CAPTURE_TIMEOUT_EN to add TIMEOUT_CYCLES
// and a 16-bit idle counter that aborts a stalled capture into ERROR.
// ----------------------------------------------------------------------------
module iir_resp_capture
    import iir_pkg::*;
#(
    parameter int CONFIG_SIZE    = CONFIG_SIZE_DEF,
    parameter int DATA_BITS      = DATA_BITS_DEF,
    parameter int DEPTH          = 1024,
    parameter int ADDR_BITS      = 10
`ifdef IIR_RESP_CAPTURE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CONFIG_SIZE-1:0] config_nfft,
    input  logic                   start,
    output logic                   busy,
    output logic                   capture_done,
    output logic                   error,
    iir_resp_capture_if.slave      bus
);

    state_t                 state, state_nx;
    logic [CONFIG_SIZE-1:0] nfft_r, nfft_nx;
    logic [CONFIG_SIZE-1:0] wr_ptr, wr_ptr_nx;
    logic                   ovf_r, ovf_nx;
    logic                   eval_r, eval_nx;
    logic                   busy_r, busy_nx;
    logic                   done_r, done_nx;
    logic                   err_r, err_nx;
    logic                   mem_we;
    logic                   cfg_bad;

`ifdef IIR_RESP_CAPTURE_TIMEOUT_EN
    logic [15:0]            tmo_cnt, tmo_nx;
`endif

    assign cfg_bad = (config_nfft == '0) || (config_nfft > CONFIG_SIZE'(DEPTH));

    // ---- control state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            nfft_r <= '0;
            wr_ptr <= '0;
            ovf_r  <= 1'b0;
            eval_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
`ifdef IIR_RESP_CAPTURE_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            state  <= state_nx;
            nfft_r <= nfft_nx;
            wr_ptr <= wr_ptr_nx;
            ovf_r  <= ovf_nx;
            eval_r <= eval_nx;
            busy_r <= busy_nx;
            done_r <= done_nx;
            err_r  <= err_nx;
`ifdef IIR_RESP_CAPTURE_TIMEOUT_EN
            tmo_cnt <= tmo_nx;
`endif
        end
    end

    // ---- next-state / next-output logic ----
    always_comb begin
        state_nx  = state;
        nfft_nx   = nfft_r;
        wr_ptr_nx = wr_ptr;
        ovf_nx    = ovf_r;
        eval_nx   = eval_r;
        busy_nx   = busy_r;
        done_nx   = done_r;
        err_nx    = err_r;
        mem_we    = 1'b0;
`ifdef IIR_RESP_CAPTURE_TIMEOUT_EN
        tmo_nx    = tmo_cnt;
`endif

        unique case (state)
            // IDLE, DONE and ERROR share the start-accept path; start while
            // busy cannot reach here, so it is ignored by construction.
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    nfft_nx   = config_nfft;
                    wr_ptr_nx = '0;
                    ovf_nx    = 1'b0;
                    done_nx   = 1'b0;
                    if (cfg_bad) begin
                        state_nx = S_ERROR;
                        err_nx   = 1'b1;
                        busy_nx  = 1'b0;
                        eval_nx  = 1'b0;
                    end else begin
                        state_nx = S_REQUEST;
                        err_nx   = 1'b0;
                        busy_nx  = 1'b1;
                        eval_nx  = 1'b1;
                    end
                end
            end

            S_REQUEST: begin
                state_nx = S_CAPTURE;
`ifdef IIR_RESP_CAPTURE_TIMEOUT_EN
                tmo_nx   = '0;
`endif
            end

            S_CAPTURE: begin
                if (bus.freq_eval_done) begin
                    // Trailer beat (valid+done) is never stored.
                    eval_nx  = 1'b0;
                    state_nx = S_DRAIN;
                end else if (bus.tf_val_valid) begin
`ifdef IIR_RESP_CAPTURE_TIMEOUT_EN
                    tmo_nx = '0;
`endif
                    if (wr_ptr < nfft_r) begin
                        mem_we    = 1'b1;
                        wr_ptr_nx = wr_ptr + CONFIG_SIZE'(1);
                    end else begin
                        ovf_nx = 1'b1;
                    end
                end
`ifdef IIR_RESP_CAPTURE_TIMEOUT_EN
                else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    eval_nx  = 1'b0;
                    state_nx = S_ERROR;
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                end else begin
                    tmo_nx = tmo_cnt + 16'd1;
                end
`endif
            end

            // Request is already low here; one full cycle low lets the
            // evaluator's wait state observe it before any new start.
            S_DRAIN: begin
                busy_nx = 1'b0;
                if ((wr_ptr == nfft_r) && !ovf_r) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = S_ERROR;
                    err_nx   = 1'b1;
                end
            end

            default: begin
                state_nx = S_IDLE;
                eval_nx  = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    assign busy                   = busy_r;
    assign capture_done           = done_r;
    assign error                  = err_r;
    assign bus.eval_iir_freq_resp = eval_r;

    // ---- read path ----
    // Reads are only enabled once capture is complete, so the single memory
    // port is never asked to read and write in the same cycle.
    logic                   rd_fire;
    logic                   rd_oor;
    logic [ADDR_BITS-1:0]   mem_addr;
    logic [2*DATA_BITS-1:0] mem_q;
    logic                   vld_p1;
    logic                   zero_p1;

    assign rd_fire  = bus.rd_en && done_r;
    assign rd_oor   = CONFIG_SIZE'(bus.rd_addr) >= nfft_r;
    assign mem_addr = done_r ? bus.rd_addr : wr_ptr[ADDR_BITS-1:0];

    resp_buffer_mem #(
        .DEPTH    (DEPTH),
        .ADDR_BITS(ADDR_BITS),
        .WIDTH    (2 * DATA_BITS)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .re   (rd_fire),
        .addr (mem_addr),
        .wdata({bus.tf_val_magnitude, bus.tf_val_phase}),
        .rdata(mem_q)
    );

    // ---- read stage p1 ----
    // zero_p1 masks the unreset memory register after reset and forces
    // out-of-range reads to zero; it only changes on an accepted read, so
    // the presented data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            zero_p1 <= 1'b1;
        end else begin
            vld_p1 <= rd_fire;
            if (rd_fire) begin
                zero_p1 <= rd_oor;
            end
        end
    end

    assign bus.rd_valid     = vld_p1;
    assign bus.rd_magnitude = zero_p1 ? '0 : mem_q[2*DATA_BITS-1:DATA_BITS];
    assign bus.rd_phase     = zero_p1 ? '0 : mem_q[DATA_BITS-1:0];

endmodule

// File: tb/tb_iir_resp_capture.sv
// ----------------------------------------------------------------------------
// tb_iir_resp_capture
// Directed, table-driven bench for iir_resp_capture. Each table row is one
// capture run (nfft, number of data beats, expected outcome); hand-written
// sequences cover handshake hold-off, start-while-busy, reads without a
// complete vector, asynchronous reset mid-capture and (with
// IIR_RESP_CAPTURE_TIMEOUT_EN) the idle timeout.
// ----------------------------------------------------------------------------
module tb_iir_resp_capture;
    import iir_pkg::*;

    localparam int CS = 16;
    localparam int DB = 16;
    localparam int AB = 10;
    localparam int TMO = 16;

    logic          clk;
    logic          rst_n;
    logic [CS-1:0] config_nfft;
    logic          start;
    logic          busy;
    logic          capture_done;
    logic          error;

    iir_resp_capture_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) bus ();

    iir_resp_capture #(
        .CONFIG_SIZE(CS),
        .DATA_BITS  (DB),
        .DEPTH      (1024),
        .ADDR_BITS  (AB)
`ifdef IIR_RESP_CAPTURE_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .config_nfft (config_nfft),
        .start       (start),
        .busy        (busy),
        .capture_done(capture_done),
        .error       (error),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    logic [DB-1:0] last_mag;
    logic [DB-1:0] last_ph;

    typedef struct {
        int nfft;
        int nvalid;
        bit legal;
        bit exp_done;
        bit exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DB-1:0] smag(input int v, input int i);
        return DB'(i * 16 + v);
    endfunction

    function automatic logic [DB-1:0] sph(input int v, input int i);
        return DB'(i + v * 256);
    endfunction

    task automatic do_start(input int n);
        config_nfft = CS'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int v, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            bus.tf_val_valid     = 1'b1;
            bus.tf_val_magnitude = smag(v, i);
            bus.tf_val_phase     = sph(v, i);
            tick();
        end
        bus.tf_val_valid = 1'b0;
    endtask

    task automatic trailer();
        bus.tf_val_valid     = 1'b1;
        bus.freq_eval_done   = 1'b1;
        bus.tf_val_magnitude = 16'hdead;
        bus.tf_val_phase     = 16'hbeef;
        tick();
        bus.tf_val_valid   = 1'b0;
        bus.freq_eval_done = 1'b0;
    endtask

    task automatic rd(input int addr, input bit exp_vld, input logic [DB-1:0] em,
                      input logic [DB-1:0] ep);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AB'(addr);
        tick();
        bus.rd_en = 1'b0;
        check($sformatf("rd_valid[%0d]", addr), 32'(bus.rd_valid), 32'(exp_vld));
        check($sformatf("rd_mag[%0d]", addr), 32'(bus.rd_magnitude), 32'(em));
        check($sformatf("rd_ph[%0d]", addr), 32'(bus.rd_phase), 32'(ep));
        last_mag = em;
        last_ph  = ep;
    endtask

    task automatic run_vec(input int v, input vec_t t);
        do_start(t.nfft);
        if (!t.legal) begin
            check($sformatf("v%0d err_cfg", v), 32'(error), 32'd1);
            check($sformatf("v%0d eval_cfg", v), 32'(bus.eval_iir_freq_resp), 32'd0);
            check($sformatf("v%0d busy_cfg", v), 32'(busy), 32'd0);
            for (int k = 0; k < 4; k++) begin
                tick();
                check($sformatf("v%0d eval_hold", v), 32'(bus.eval_iir_freq_resp), 32'd0);
            end
            return;
        end
        check($sformatf("v%0d eval_req", v), 32'(bus.eval_iir_freq_resp), 32'd1);
        check($sformatf("v%0d busy_req", v), 32'(busy), 32'd1);
        check($sformatf("v%0d err_clr", v), 32'(error), 32'd0);
        check($sformatf("v%0d done_clr", v), 32'(capture_done), 32'd0);
        tick();
        feed(v, 0, t.nvalid);
        trailer();
        check($sformatf("v%0d eval_drop", v), 32'(bus.eval_iir_freq_resp), 32'd0);
        tick();
        check($sformatf("v%0d capture_done", v), 32'(capture_done), 32'(t.exp_done));
        check($sformatf("v%0d error", v), 32'(error), 32'(t.exp_err));
        check($sformatf("v%0d busy_end", v), 32'(busy), 32'd0);
        if (t.nvalid > t.nfft) begin
            for (int i = 0; i < t.nfft; i++) begin
                check($sformatf("v%0d mem[%0d]", v, i), u_dut.u_mem.mem[i],
                      {smag(v, i), sph(v, i)});
            end
        end
        if (t.exp_done) begin
            for (int i = 0; i < t.nfft; i++) begin
                rd(i, 1'b1, smag(v, i), sph(v, i));
            end
            rd(t.nfft + 1, 1'b1, '0, '0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last_mag = '0;
        last_ph  = '0;

        //           nfft  nvalid legal done err
        vecs[0] = '{ 8,    8,     1'b1, 1'b1, 1'b0 };
        vecs[1] = '{ 8,    7,     1'b1, 1'b0, 1'b1 };
        vecs[2] = '{ 4,    6,     1'b1, 1'b0, 1'b1 };
        vecs[3] = '{ 0,    0,     1'b0, 1'b0, 1'b1 };
        vecs[4] = '{ 2048, 0,     1'b0, 1'b0, 1'b1 };
        vecs[5] = '{ 2,    2,     1'b1, 1'b1, 1'b0 };
        vecs[6] = '{ 1,    1,     1'b1, 1'b1, 1'b0 };
        vecs[7] = '{ 16,   16,    1'b1, 1'b1, 1'b0 };

        rst_n                = 1'b0;
        start                = 1'b0;
        config_nfft          = '0;
        bus.tf_val_valid     = 1'b0;
        bus.freq_eval_done   = 1'b0;
        bus.tf_val_magnitude = '0;
        bus.tf_val_phase     = '0;
        bus.rd_en            = 1'b0;
        bus.rd_addr          = '0;
        tick();
        tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(capture_done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        check("rst eval", 32'(bus.eval_iir_freq_resp), 32'd0);
        check("rst rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst rd_mag", 32'(bus.rd_magnitude), 32'd0);
        check("rst rd_ph", 32'(bus.rd_phase), 32'd0);
        rst_n = 1'b1;
        tick();

        // Stray stream activity in IDLE must not change anything.
        feed(9, 0, 2);
        trailer();
        check("stray busy", 32'(busy), 32'd0);
        check("stray eval", 32'(bus.eval_iir_freq_resp), 32'd0);

        for (int v = 0; v < 8; v++) begin
            run_vec(v, vecs[v]);
        end

        // After a completed capture the request stays low without a new start.
        for (int k = 0; k < 5; k++) begin
            tick();
            check("no_rerequest", 32'(bus.eval_iir_freq_resp), 32'd0);
        end

        // Start while busy is ignored: nfft 4 stays in force.
        do_start(4);
        tick();
        feed(20, 0, 2);
        config_nfft = CS'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start busy", 32'(busy), 32'd1);
        check("busy_start eval", 32'(bus.eval_iir_freq_resp), 32'd1);
        feed(20, 2, 2);
        trailer();
        tick();
        check("busy_start done", 32'(capture_done), 32'd1);
        check("busy_start err", 32'(error), 32'd0);
        rd(3, 1'b1, smag(20, 3), sph(20, 3));

        // Short vector, then reads while capture_done is low.
        do_start(8);
        tick();
        feed(21, 0, 7);
        trailer();
        tick();
        check("short err", 32'(error), 32'd1);
        check("short done", 32'(capture_done), 32'd0);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AB'(0);
        tick();
        bus.rd_en = 1'b0;
        check("nodone rd_valid", 32'(bus.rd_valid), 32'd0);
        check("nodone rd_mag held", 32'(bus.rd_magnitude), 32'(last_mag));
        check("nodone rd_ph held", 32'(bus.rd_phase), 32'(last_ph));

        // Asynchronous reset in the middle of a capture.
        do_start(8);
        tick();
        feed(22, 0, 3);
        bus.tf_val_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst eval", 32'(bus.eval_iir_freq_resp), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(capture_done), 32'd0);
        check("arst error", 32'(error), 32'd0);
        check("arst rd_mag", 32'(bus.rd_magnitude), 32'd0);
        bus.tf_val_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_vec(23, '{ 2, 2, 1'b1, 1'b1, 1'b0 });

`ifdef IIR_RESP_CAPTURE_TIMEOUT_EN
        // No data: error after TMO CAPTURE cycles following the REQUEST cycle.
        begin
            int n;
            n = 0;
            do_start(4);
            while (!error && n < 200) begin
                tick();
                n++;
            end
            check("tmo cycles", 32'(n), 32'(TMO + 1));
            check("tmo error", 32'(error), 32'd1);
            check("tmo eval", 32'(bus.eval_iir_freq_resp), 32'd0);
            check("tmo busy", 32'(busy), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
